// File: rtl/uart_pkg.sv
// Shared UART types and defaults, used by the RX bit timer and later by the TX side.
package uart_pkg;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam int unsigned ClkHzDef  = 50_000_000;
   localparam int unsigned BaudDef   = 9600;
   localparam int unsigned MinDivDef = 4;

   // Clocks per bit, truncated.
   function automatic int unsigned div_from_baud(input int unsigned clk_hz,
                                                 input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_div_cnt.sv
// Modulo-div counter with synchronous clear and enable; wrap_o flags the last count.
module uart_div_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] div_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign wrap_o = (cnt_q == div_i - W'(1));
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_bit_timer.sv
// RX bit timer: per-bit mid/end strobes, bit index and frame-done for the RX control FSM.
module uart_rx_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = ClkHzDef,
   parameter int unsigned BAUD       = BaudDef,
   parameter int unsigned DIV_W      = 16,
   parameter int unsigned FRAME_BITS = 10,
   parameter int unsigned MIN_DIV    = MinDivDef
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          Count_En,
   input  logic                          Div_Load,
   input  logic [DIV_W-1:0]              Div_Value,
   output logic                          Mid_Pulse,
   output logic                          Bit_End,
   output logic [$clog2(FRAME_BITS)-1:0] Bit_Idx,
   output logic                          Frame_Done,
   output logic                          Busy,
   output logic                          Div_Err,
   output logic [DIV_W-1:0]              Div_Cur
);

   localparam int unsigned DivRst = div_from_baud(CLK_HZ, BAUD);
   localparam int unsigned IdxW   = $clog2(FRAME_BITS);

   if (DivRst < MIN_DIV || longint'(DivRst) >= (longint'(1) << DIV_W)) begin : g_div_rst_check
      $fatal(1, "uart_rx_bit_timer: reset divisor out of range");
   end

   state_e           state_q;
   logic [IdxW-1:0]  bit_idx_q;
   logic [DIV_W-1:0] div_cur_q;
   logic             div_err_q;

   logic             run;
   logic [DIV_W-1:0] cnt;
   logic             cnt_wrap;
   logic             div_ok;

   assign run = (state_q == StRun);

   // Counter is held at zero in idle and cleared on abort so a restart always begins at bit 0.
   uart_div_cnt #(
      .W(DIV_W)
   ) u_div_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (!run || !Count_En),
      .en_i  (run),
      .div_i (div_cur_q),
      .cnt_o (cnt),
      .wrap_o(cnt_wrap)
   );

   assign Mid_Pulse  = run && (cnt == (div_cur_q >> 1));
   assign Bit_End    = run && cnt_wrap;
   assign Frame_Done = Bit_End && (bit_idx_q == IdxW'(FRAME_BITS - 1));

   // A start request in the same cycle takes priority over a divisor load.
   assign div_ok = Div_Load && (state_q == StIdle) && !Count_En &&
                   (Div_Value >= DIV_W'(MIN_DIV));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         bit_idx_q <= '0;
         div_cur_q <= DIV_W'(DivRst);
         div_err_q <= 1'b0;
      end else begin
         div_err_q <= Div_Load && !div_ok;
         if (div_ok) begin
            div_cur_q <= Div_Value;
         end
         unique case (state_q)
            StIdle: begin
               bit_idx_q <= '0;
               if (Count_En) begin
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (!Count_En) begin
                  state_q   <= StIdle;
                  bit_idx_q <= '0;
               end else if (Frame_Done) begin
                  bit_idx_q <= '0;
               end else if (Bit_End) begin
                  bit_idx_q <= bit_idx_q + IdxW'(1);
               end
            end
         endcase
      end
   end

   assign Bit_Idx = bit_idx_q;
   assign Busy    = run;
   assign Div_Err = div_err_q;
   assign Div_Cur = div_cur_q;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Directed bench for uart_rx_bit_timer at default parameters (divisor 5208).
module tb_uart_rx_bit_timer;

   logic        clk;
   logic        rst;
   logic        count_en;
   logic        div_load;
   logic [15:0] div_value;
   logic        mid;
   logic        bit_end;
   logic [3:0]  bit_idx;
   logic        frame_done;
   logic        busy;
   logic        div_err;
   logic [15:0] div_cur;

   int n_checks = 0;
   int n_errors = 0;
   int rc, mid_cnt, be_cnt, fd_cnt, mid1, mid2, be1, fd_cyc, fd_idx, max_idx;

   uart_rx_bit_timer dut (
      .CLK       (clk),
      .RST       (rst),
      .Count_En  (count_en),
      .Div_Load  (div_load),
      .Div_Value (div_value),
      .Mid_Pulse (mid),
      .Bit_End   (bit_end),
      .Bit_Idx   (bit_idx),
      .Frame_Done(frame_done),
      .Busy      (busy),
      .Div_Err   (div_err),
      .Div_Cur   (div_cur)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      mid_cnt = 0; be_cnt = 0; fd_cnt = 0;
      mid1 = 0; mid2 = 0; be1 = 0; fd_cyc = 0; fd_idx = 0; max_idx = 0;
   endtask

   // Advance n cycles, logging strobe positions by RUN cycle number; drop Count_En after drop_at.
   task automatic observe(input int n, input int drop_at);
      for (int i = 0; i < n; i++) begin
         tick();
         rc++;
         if (mid) begin
            mid_cnt++;
            if (mid_cnt == 1) mid1 = rc;
            else if (mid_cnt == 2) mid2 = rc;
         end
         if (bit_end) begin
            be_cnt++;
            if (be_cnt == 1) be1 = rc;
         end
         if (frame_done) begin
            fd_cnt++;
            fd_cyc = rc;
            fd_idx = int'(bit_idx);
         end
         if (int'(bit_idx) > max_idx) max_idx = int'(bit_idx);
         if (rc == drop_at) count_en = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; count_en = 1'b1; div_load = 1'b0; div_value = '0;
      rc = 0;
      clear_stats();

      // 1: default divisor, Count_En held through reset
      tick();
      tick();
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_div_cur", 32'(div_cur), 5208);
      check_eq("rst_bit_idx", 32'(bit_idx), 0);
      check_eq("rst_strobes", 32'({mid, bit_end, frame_done, div_err}), 0);
      rst = 1'b0;
      observe(52080, 0);
      check_eq("t1_mid1", mid1, 2605);
      check_eq("t1_mid2", mid2, 7813);
      check_eq("t1_be1", be1, 5208);
      check_eq("t1_mid_cnt", mid_cnt, 10);
      check_eq("t1_be_cnt", be_cnt, 10);
      check_eq("t1_fd_cnt", fd_cnt, 1);
      check_eq("t1_fd_cyc", fd_cyc, 52080);
      check_eq("t1_fd_idx", fd_idx, 9);
      check_eq("t1_max_idx", max_idx, 9);
      tick();
      check_eq("t1_b2b_idx", 32'(bit_idx), 0);
      check_eq("t1_b2b_busy", 32'(busy), 1);
      check_eq("t1_b2b_fd", 32'(frame_done), 0);
      count_en = 1'b0;
      tick();
      check_eq("t1_idle", 32'(busy), 0);

      // 2: load 10, one frame, Count_En dropped on Frame_Done
      div_load = 1'b1; div_value = 16'd10;
      tick();
      div_load = 1'b0;
      check_eq("t2_div_cur", 32'(div_cur), 10);
      check_eq("t2_div_err", 32'(div_err), 0);
      count_en = 1'b1; rc = 0; clear_stats();
      observe(100, 100);
      check_eq("t2_mid1", mid1, 6);
      check_eq("t2_mid2", mid2, 16);
      check_eq("t2_mid_cnt", mid_cnt, 10);
      check_eq("t2_fd_cyc", fd_cyc, 100);
      check_eq("t2_fd_idx", fd_idx, 9);
      tick();
      check_eq("t2_busy_end", 32'(busy), 0);
      check_eq("t2_idx_end", 32'(bit_idx), 0);

      // 3: rejected loads (too small, and while busy)
      div_load = 1'b1; div_value = 16'd3;
      tick();
      div_load = 1'b0;
      check_eq("t3_err_small", 32'(div_err), 1);
      check_eq("t3_cur_small", 32'(div_cur), 10);
      tick();
      check_eq("t3_err_pulse", 32'(div_err), 0);
      count_en = 1'b1;
      tick();
      check_eq("t3_busy", 32'(busy), 1);
      div_load = 1'b1; div_value = 16'd200;
      tick();
      div_load = 1'b0;
      check_eq("t3_err_busy", 32'(div_err), 1);
      check_eq("t3_cur_busy", 32'(div_cur), 10);
      count_en = 1'b0;
      tick();
      check_eq("t3_idle", 32'(busy), 0);

      // 4: abort at RUN cycle 37, then restart
      count_en = 1'b1; rc = 0; clear_stats();
      observe(37, 37);
      check_eq("t4_idx_abort", 32'(bit_idx), 3);
      tick();
      check_eq("t4_busy", 32'(busy), 0);
      check_eq("t4_idx", 32'(bit_idx), 0);
      check_eq("t4_no_fd", fd_cnt, 0);
      count_en = 1'b1; rc = 0; clear_stats();
      observe(12, 0);
      check_eq("t4_re_mid1", mid1, 6);
      check_eq("t4_re_be1", be1, 10);
      check_eq("t4_re_idx", 32'(bit_idx), 1);
      observe(53, 0);
      check_eq("t5_pre_idx", 32'(bit_idx), 6);

      // 5: reset mid-frame
      rst = 1'b1; count_en = 1'b0;
      tick();
      rst = 1'b0;
      check_eq("t5_busy", 32'(busy), 0);
      check_eq("t5_idx", 32'(bit_idx), 0);
      check_eq("t5_strobes", 32'({mid, bit_end, frame_done, div_err}), 0);
      check_eq("t5_div_cur", 32'(div_cur), 5208);

      // 6: load+start collision, then odd divisor 5
      div_load = 1'b1; div_value = 16'd10;
      tick();
      check_eq("t6_div10", 32'(div_cur), 10);
      div_value = 16'd5; count_en = 1'b1;
      tick();
      div_load = 1'b0;
      check_eq("t6_coll_err", 32'(div_err), 1);
      check_eq("t6_coll_cur", 32'(div_cur), 10);
      check_eq("t6_coll_busy", 32'(busy), 1);
      clear_stats(); rc = 1;
      observe(9, 0);
      check_eq("t6_coll_mid1", mid1, 6);
      check_eq("t6_coll_be1", be1, 10);
      count_en = 1'b0;
      tick();
      div_load = 1'b1; div_value = 16'd5;
      tick();
      div_load = 1'b0;
      check_eq("t6_div5", 32'(div_cur), 5);
      check_eq("t6_div5_err", 32'(div_err), 0);
      count_en = 1'b1; rc = 0; clear_stats();
      observe(50, 50);
      check_eq("t6_mid1", mid1, 3);
      check_eq("t6_mid2", mid2, 8);
      check_eq("t6_be1", be1, 5);
      check_eq("t6_mid_cnt", mid_cnt, 10);
      check_eq("t6_fd_cyc", fd_cyc, 50);
      tick();
      check_eq("t6_busy_end", 32'(busy), 0);

      // Smallest legal divisor is accepted
      div_load = 1'b1; div_value = 16'd4;
      tick();
      div_load = 1'b0;
      check_eq("min_div_cur", 32'(div_cur), 4);
      check_eq("min_div_err", 32'(div_err), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_bit_timer.md
Name: uart_rx_bit_timer

Overview:
- Parametrised successor to the fixed 9600 bps RX bit-rate counter.
- Generates per-bit timing strobes for the UART receive controller:
  - mid-bit sample pulse
  - end-of-bit pulse
  - bit index
  - end-of-frame pulse
- Divisor comes from parameters at reset and can be reloaded at runtime while idle.
- Sits between the RX start-bit detector (drives Count_En) and the RX shift/control FSM (consumes Mid_Pulse, Bit_Idx, Frame_Done).

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, default bit rate; reset divisor DIV_RST = CLK_HZ/BAUD (integer truncation; 5208 at defaults).
- DIV_W, 16, width of divisor and bit-period counter.
- FRAME_BITS, 10, bit periods per frame (start + 8 data + stop).
- MIN_DIV, 4, smallest legal runtime divisor.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- Count_En  in  1  high = time a frame; low = abort and return to idle.
- Div_Load  in  1  single-cycle request to load Div_Value.
- Div_Value  in  DIV_W  new clocks-per-bit value.
- Mid_Pulse  out  1  one-cycle strobe at bit centre.
- Bit_End  out  1  one-cycle strobe on last clock of each bit period.
- Bit_Idx  out  $clog2(FRAME_BITS)  index of current bit, 0 = start bit.
- Frame_Done  out  1  one-cycle strobe on last clock of the final bit.
- Busy  out  1  high while in RUN.
- Div_Err  out  1  one-cycle strobe when a Div_Load is rejected.
- Div_Cur  out  DIV_W  active divisor.

Behaviour:
- Reset (RST sampled high at a CLK edge):
  - State = IDLE, cnt = 0, Bit_Idx = 0, Div_Cur = DIV_RST.
  - Mid_Pulse, Bit_End, Frame_Done, Busy and Div_Err all 0.
  - Reset overrides all other inputs in the same cycle.
- State machine: IDLE and RUN.
- IDLE -> RUN when Count_En = 1 at an edge.
  - The first RUN cycle has cnt = 0 and Bit_Idx = 0.
- RUN:
  - cnt increments by 1 each cycle.
  - When cnt == Div_Cur-1: cnt wraps to 0 and Bit_Idx increments.
  - cnt never exceeds Div_Cur-1.
- Strobe decodes (from registered cnt/Bit_Idx, RUN only, zero added latency):
  - Mid_Pulse = (cnt == Div_Cur>>1). Gives 2604 at default, so the first Mid_Pulse is in the 2605th RUN cycle.
  - Bit_End = (cnt == Div_Cur-1).
  - Frame_Done = Bit_End && (Bit_Idx == FRAME_BITS-1).
- On Frame_Done:
  - If Count_En = 1 that cycle: remain RUN with cnt = 0 and Bit_Idx = 0 (back-to-back frames, no gap).
  - If Count_En = 0: go to IDLE.
- Count_En = 0 in RUN, not on a Frame_Done cycle: next state IDLE with cnt and Bit_Idx cleared. All strobes in the abort cycle are still decoded normally.
- Busy = (state == RUN).
- Div_Load accepted only when all hold: state IDLE, Count_En = 0 in the same cycle, and MIN_DIV <= Div_Value.
  - Accepted: Div_Cur = Div_Value from the next cycle.
  - Otherwise: Div_Cur unchanged and Div_Err = 1 in the next cycle.
- Div_Load and Count_En both high in IDLE: the start wins, the load is rejected (Div_Err), and the frame uses the old Div_Cur.
- Div_Cur never changes during RUN.
- Odd divisor: centre rounds down (Div_Cur = 5 gives Mid_Pulse at cnt = 2).
- Bit_Idx never reaches FRAME_BITS.
- Arithmetic is unsigned, DIV_W bits, with no overflow since Div_Cur <= 2^DIV_W - 1.
- Elaboration check: DIV_RST >= MIN_DIV and DIV_RST < 2^DIV_W, otherwise fatal.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, RUN}
  - default CLK_HZ and BAUD
  - MIN_DIV
  - function div_from_baud(clk_hz, baud)
- One sub-module: uart_div_cnt.
  - A DIV_W-bit modulo counter with clear/enable.
  - Outputs cnt and wrap.
  - Reusable by the TX side later.
- The top holds the FSM, Bit_Idx, divisor register and strobe decode.

Test Plan:
1. Defaults, RST for 2 cycles, Count_En held high from cycle 0 -> Mid_Pulse at RUN cycles 2605, 7813, ...; Bit_End at 5208, 10416, ...; Frame_Done at RUN cycle 52080 with Bit_Idx = 9; if Count_En is still high, Bit_Idx = 0 next cycle.
2. Idle, Div_Load with Div_Value = 10, then Count_En high -> Div_Cur = 10; Mid_Pulse every 10 cycles at cnt = 5; Frame_Done after 100 RUN cycles; Count_En dropped on that cycle -> IDLE, Busy = 0.
3. Div_Load of 3, then Div_Load of 200 issued while Busy -> both give Div_Err = 1 for one cycle; Div_Cur unchanged (10).
4. Div_Cur = 10, Count_En dropped at RUN cycle 37 (Bit_Idx = 3) -> next cycle IDLE, cnt = 0, Bit_Idx = 0, no Frame_Done; re-assertion restarts at bit 0.
5. RST asserted mid-frame (Div_Cur = 10, Bit_Idx = 6) -> next cycle all outputs 0, Div_Cur = 5208.
6. Div_Value = 5 (odd) with Div_Load and Count_En in the same cycle -> Div_Err = 1 and the frame runs with the previous divisor; then load 5 alone -> Mid_Pulse at cnt = 2, Bit_End at cnt = 4.
